// File: rtl/remote_unit_responder.sv
// Remote-unit endpoint of the power-up handshake: timed ramp on ctrl, reports ready, trips on debounced pwr_ok loss.
// Latency: ready rises RAMP_CYCLES edges after RAMP entry; ready/tripped are registered from the next state.
// Backpressure: none; a trip is held until the sequencer acknowledges by dropping ctrl, then a cooldown runs.
module remote_unit_responder #(
  parameter int RAMP_CYCLES = 6,
  parameter int DEBOUNCE    = 3,
  parameter int COOLDOWN    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl,
  input  logic       pwr_ok,
  output logic       ready,
  output logic       tripped,
  output logic [3:0] trip_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    RAMP = 3'd1,
    ON   = 3'd2,
    TRIP = 3'd3,
    COOL = 3'd4
  } state_t;

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_CYCLES - 1);
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [7:0] bad;
  logic [7:0] bad_next;

  // Next-state decode; ctrl loss in ON outranks a trip on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      OFF:  if (ctrl) state_next = RAMP;
      RAMP: begin
        if (!ctrl)                 state_next = OFF;
        else if (cnt == RAMP_LAST) state_next = ON;
      end
      ON: begin
        if (!ctrl)                            state_next = OFF;
        else if (!pwr_ok && bad == DEB_LAST)  state_next = TRIP;
      end
      TRIP: if (!ctrl) state_next = COOL;
      COOL: if (cnt == COOL_LAST) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  // Phase counter runs only while dwelling in RAMP/COOL; debounce counter only while staying in ON.
  always_comb begin
    cnt_next = 8'd0;
    bad_next = 8'd0;
    if (state_next == state && (state == RAMP || state == COOL)) begin
      cnt_next = cnt + 8'd1;
    end
    if (state == ON && state_next == ON && !pwr_ok) begin
      bad_next = bad + 8'd1;
    end
  end

  // State, counters and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= OFF;
      cnt        <= 8'd0;
      bad        <= 8'd0;
      ready      <= 1'b0;
      tripped    <= 1'b0;
      trip_count <= 4'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bad     <= bad_next;
      ready   <= (state_next == ON);
      tripped <= (state_next == TRIP) || (state_next == COOL);
      if (state_next == TRIP && state != TRIP && trip_count != 4'hF) begin
        trip_count <= trip_count + 4'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_remote_unit_responder.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with an edge number,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_remote_unit_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ctrl;
  logic       pwr_ok;
  logic       ready;
  logic       tripped;
  logic [3:0] trip_count;
  logic [2:0] state_o;

  localparam logic [2:0] S_OFF = 3'd0, S_RAMP = 3'd1, S_ON = 3'd2, S_TRIP = 3'd3, S_COOL = 3'd4;

  typedef struct {
    int         at;
    string      name;
    logic [2:0] st;
    logic       rdy;
    logic       trp;
    logic [3:0] tc;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  remote_unit_responder dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .pwr_ok     (pwr_ok),
    .ready      (ready),
    .tripped    (tripped),
    .trip_count (trip_count),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: compare every expectation due at or before the current edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= edge_n) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 1;
      if ({state_o, ready, tripped, trip_count} !== {e.st, e.rdy, e.trp, e.tc}) begin
        errors = errors + 1;
        $display("FAIL %s edge=%0d got state=%0d ready=%0b tripped=%0b trip_count=%0d want state=%0d ready=%0b tripped=%0b trip_count=%0d",
                 e.name, edge_n, state_o, ready, tripped, trip_count, e.st, e.rdy, e.trp, e.tc);
      end
    end
  end

  // Expect the given outputs after the k-th upcoming edge (k=1 samples the next inputs).
  task automatic exp_after(input int k, input string nm, input logic [2:0] st,
                           input logic rdy, input logic trp, input logic [3:0] tc);
    exp_t e;
    e.at = edge_n + k; e.name = nm; e.st = st; e.rdy = rdy; e.trp = trp; e.tc = tc;
    q.push_back(e);
  endtask

  task automatic cyc(input logic c, input logic p);
    ctrl = c;
    pwr_ok = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    errors = errors + 1;
    $display("FAIL timeout edge=%0d pending=%0d", edge_n, q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b0; ctrl = 1'b0; pwr_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_after(0, "reset_state", S_OFF, 0, 0, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Normal power-up, then ctrl drop from ON.
    exp_after(1, "pu_ramp_entry", S_RAMP, 0, 0, 4'd0);
    exp_after(6, "pu_ramp_last", S_RAMP, 0, 0, 4'd0);
    exp_after(7, "pu_on", S_ON, 1, 0, 4'd0);
    exp_after(20, "pu_on_hold", S_ON, 1, 0, 4'd0);
    repeat (20) cyc(1, 1);
    exp_after(1, "pu_ctrl_drop", S_OFF, 0, 0, 4'd0);
    cyc(0, 1);
    cyc(0, 1);

    // Ramp abort, then a full restart.
    exp_after(3, "abort_ramp", S_RAMP, 0, 0, 4'd0);
    exp_after(4, "abort_off", S_OFF, 0, 0, 4'd0);
    exp_after(5, "abort_stay_off", S_OFF, 0, 0, 4'd0);
    repeat (3) cyc(1, 1);
    cyc(0, 1);
    cyc(0, 1);
    exp_after(6, "restart_ramp_last", S_RAMP, 0, 0, 4'd0);
    exp_after(7, "restart_on", S_ON, 1, 0, 4'd0);
    repeat (8) cyc(1, 1);

    // Debounce: 2 low samples do not trip, 3 do.
    exp_after(3, "deb_no_trip", S_ON, 1, 0, 4'd0);
    cyc(1, 0); cyc(1, 0); cyc(1, 1);
    exp_after(2, "deb_two_low", S_ON, 1, 0, 4'd0);
    exp_after(3, "deb_trip", S_TRIP, 0, 1, 4'd1);
    cyc(1, 0); cyc(1, 0); cyc(1, 0);

    // Trip hold, acknowledgement, cooldown, re-ramp.
    exp_after(20, "trip_hold", S_TRIP, 0, 1, 4'd1);
    repeat (20) cyc(1, 1);
    exp_after(1, "cool_entry", S_COOL, 0, 1, 4'd1);
    exp_after(8, "cool_last", S_COOL, 0, 1, 4'd1);
    exp_after(9, "cool_off", S_OFF, 0, 0, 4'd1);
    exp_after(10, "cool_reramp", S_RAMP, 0, 0, 4'd1);
    exp_after(15, "cool_ramp_last", S_RAMP, 0, 0, 4'd1);
    exp_after(16, "cool_on", S_ON, 1, 0, 4'd1);
    cyc(0, 1); cyc(0, 1);
    repeat (14) cyc(1, 1);

    // ctrl fall coincides with the 3rd low pwr_ok sample: OFF wins.
    exp_after(3, "simul_off", S_OFF, 0, 0, 4'd1);
    cyc(1, 0); cyc(1, 0); cyc(0, 0);
    cyc(0, 1);

    // Trip count saturation over 15 further trips.
    for (int i = 0; i < 15; i++) begin
      logic [3:0] tc;
      tc = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      exp_after(10, "sat_trip", S_TRIP, 0, 1, tc);
      exp_after(19, "sat_off", S_OFF, 0, 0, tc);
      repeat (7) cyc(1, 1);
      repeat (3) cyc(1, 0);
      repeat (9) cyc(0, 1);
    end

    // Asynchronous reset mid-RAMP, then release with ctrl high.
    exp_after(2, "rst_pre_ramp", S_RAMP, 0, 0, 4'd15);
    repeat (3) cyc(1, 1);
    exp_after(0, "rst_async", S_OFF, 0, 0, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if (state_o !== S_OFF) begin
      errors = errors + 1;
      $display("FAIL rst_imm_state got %0d", state_o);
    end
    checks = checks + 1;
    if (ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_imm_ready got %0b", ready);
    end
    checks = checks + 1;
    if (tripped !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rst_imm_tripped got %0b", tripped);
    end
    checks = checks + 1;
    if (trip_count !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL rst_imm_trip_count got %0d", trip_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_after(1, "rel_ramp", S_RAMP, 0, 0, 4'd0);
    exp_after(6, "rel_ramp_last", S_RAMP, 0, 0, 4'd0);
    exp_after(7, "rel_on", S_ON, 1, 0, 4'd0);
    repeat (8) cyc(1, 1);
    repeat (3) cyc(0, 1);

    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      errors = errors + 1;
      $display("FAIL %s never checked at=%0d", e.name, e.at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
